ps2_kbd_rx: RTL

//  PS/2 keyboard receiver: deserialises device->host frames from ps2_clk/ps2_data and

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_clk_filter.sv | 55 +++++
 rtl/ps2_kbd_rx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM states and prefix bytes.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Two-flop synchroniser for both PS/2 pins, ps2_clk deglitch filter and falling-edge strobe.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic fall_o,
  output logic data_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    meta_q;
  logic [1:0]    sync_q;
  logic          filt_q;
  logic [CW-1:0] cnt_q;
  logic          fall_q;

  // Bit 0 carries the clock pin, bit 1 the data pin; both idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 2'b11;
      sync_q <= 2'b11;
    end else begin
      meta_q <= {ps2_data_i, ps2_clk_i};
      sync_q <= meta_q;
    end
  end

  // The filtered level flips only once FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
      fall_q <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (sync_q[0] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_q <= sync_q[0];
        cnt_q  <= '0;
        fall_q <= filt_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign fall_o = fall_q;
  assign data_o = sync_q[1];

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame deserialiser with E0/F0 prefix decode.
// Define PS2_BREAK_FILTER_EN to drop key-release codes and tie kb_break low.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] kb_code,
  output logic       kb_valid,
  output logic       kb_ext,
  output logic       kb_break,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          fall;
  logic          data_bit;
  ps2_state_e    state_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shreg_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic          ext_pend_q;
  logic          brk_pend_q;
  logic [7:0]    kb_code_q;
  logic          kb_valid_q;
  logic          kb_ext_q;
  logic          parity_err_q;
  logic          frame_err_q;
`ifndef PS2_BREAK_FILTER_EN
  logic          kb_break_q;
`endif

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .fall_o    (fall),
    .data_o    (data_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bitcnt_q     <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      kb_code_q    <= 8'h00;
      kb_valid_q   <= 1'b0;
      kb_ext_q     <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifndef PS2_BREAK_FILTER_EN
      kb_break_q   <= 1'b0;
`endif
    end else begin
      kb_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;

      // tmo_q holds the number of cycles since the last fall while a frame is open.
      if (fall) begin
        tmo_q <= TW'(1);
      end else if (state_q != ST_IDLE) begin
        tmo_q <= tmo_q + 1'b1;
      end else begin
        tmo_q <= '0;
      end

      if (!fall && state_q != ST_IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        frame_err_q <= 1'b1;
        state_q     <= ST_IDLE;
        ext_pend_q  <= 1'b0;
        brk_pend_q  <= 1'b0;
        tmo_q       <= '0;
      end else if (fall) begin
        case (state_q)
          ST_IDLE: begin
            if (data_bit) begin
              frame_err_q <= 1'b1;
              ext_pend_q  <= 1'b0;
              brk_pend_q  <= 1'b0;
            end else begin
              state_q  <= ST_DATA;
              bitcnt_q <= '0;
            end
          end
          ST_DATA: begin
            shreg_q  <= {data_bit, shreg_q[7:1]};
            bitcnt_q <= bitcnt_q + 1'b1;
            if (bitcnt_q == 3'd7) begin
              state_q <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_q   <= data_bit;
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
            if (!data_bit) begin
              frame_err_q <= 1'b1;
              ext_pend_q  <= 1'b0;
              brk_pend_q  <= 1'b0;
            end else if (!odd_parity_ok(shreg_q, par_q)) begin
              parity_err_q <= 1'b1;
              ext_pend_q   <= 1'b0;
              brk_pend_q   <= 1'b0;
            end else if (shreg_q == PS2_EXT) begin
              ext_pend_q <= 1'b1;
            end else if (shreg_q == PS2_BRK) begin
              brk_pend_q <= 1'b1;
            end else begin
`ifdef PS2_BREAK_FILTER_EN
              if (!brk_pend_q) begin
                kb_code_q  <= shreg_q;
                kb_ext_q   <= ext_pend_q;
                kb_valid_q <= 1'b1;
              end
`else
              kb_code_q  <= shreg_q;
              kb_ext_q   <= ext_pend_q;
              kb_break_q <= brk_pend_q;
              kb_valid_q <= 1'b1;
`endif
              ext_pend_q <= 1'b0;
              brk_pend_q <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign kb_code    = kb_code_q;
  assign kb_valid   = kb_valid_q;
  assign kb_ext     = kb_ext_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
`ifdef PS2_BREAK_FILTER_EN
  assign kb_break   = 1'b0;
`else
  assign kb_break   = kb_break_q;
`endif

endmodule
